log2_share_arbiter: RTL and testbench

//  Shares one log2_approx unit (Q4.12 in, Q4.12 out) between N_REQ requesters in the softmax_approx datapath.

---
 rtl/log2_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/log2_share_arbiter.sv | 128 ++++++++++++
 tb/tb_log2_share_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/log2_ctrl_pkg.sv
// Shared definitions for the log2 sharing controller: FSM encoding and Q4.12 constants.
package log2_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int          Q_FRAC = 12;
  localparam logic [15:0] Q_ONE  = 16'h1000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first pending requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic                     adv,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any_req
);

  localparam int              IW   = $clog2(N_REQ);
  localparam logic [IW-1:0]   LAST = IW'(N_REQ - 1);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_l;
  int            idx;

  // Scan from the farthest offset down so the nearest pending requester wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = IW'(idx);
      if (req_valid[idx_l]) begin
        grant   = idx_l;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (grant == LAST) ? '0 : grant + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/log2_share_arbiter.sv
// Time-shares one log2_approx unit among N_REQ requesters, with a watchdog on the unit's answer.
module log2_share_arbiter
  import log2_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_x,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      u_en,
  output logic                      u_ready,
  output logic [DATA_W-1:0]         u_in_x,
  input  logic                      u_valid,
  input  logic [DATA_W-1:0]         u_log2_x,
  output logic                      resp_valid,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   x_q, x_d, data_q, data_d;
  logic [IW-1:0]       id_q, id_d, rid_q, rid_d;
  logic                err_q, err_d, terr_q, terr_d;
  logic [IW-1:0]       grant;
  logic                any_req;
  logic                adv;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .adv       (adv),
    .grant     (grant),
    .any_req   (any_req)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    id_d      = id_q;
    rid_d     = rid_q;
    data_d    = data_q;
    err_d     = err_q;
    terr_d    = terr_q;
    adv       = 1'b0;
    req_ready = '0;
    cnt_inc   = cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // No accept pulse while reset is held, so no operand is lost.
          req_ready[grant] = rst;
          adv     = 1'b1;
          x_d     = req_x[grant*DATA_W +: DATA_W];
          id_d    = grant;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (u_valid) begin
          data_d  = u_log2_x;
          err_d   = 1'b0;
          rid_d   = id_q;
          state_d = ST_RESP;
        end else if (cnt_inc == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          terr_d  = 1'b1;
          rid_d   = id_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      id_q    <= '0;
      rid_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      terr_q  <= terr_d;
    end
  end

  assign u_en        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign u_ready     = (state_q == ST_ISSUE);
  assign u_in_x      = x_q;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_id     = rid_q;
  assign resp_data   = data_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_log2_share_arbiter.sv
// Directed bench for log2_share_arbiter; the bench plays both the requesters and the log2 unit.
module tb_log2_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 15;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic           u_en, u_ready;
  logic [W-1:0]   u_in_x;
  logic           u_valid;
  logic [W-1:0]   u_log2_x;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;

  log2_share_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_ready   (req_ready),
    .u_en        (u_en),
    .u_ready     (u_ready),
    .u_in_x      (u_in_x),
    .u_valid     (u_valid),
    .u_log2_x    (u_log2_x),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction, entered and left in IDLE just after a rising edge.
  task automatic op(input string tag, input logic [N-1:0] vmask, input logic [N-1:0] after,
                    input int exp_id, input logic [W-1:0] exp_x, input int lat,
                    input logic answer, input logic [W-1:0] ans);
    logic [N-1:0] oh;
    logic [W-1:0] exp_data;
    int           n;
    oh       = 4'b0001 << exp_id;
    exp_data = answer ? ans : '0;
    req_valid = vmask;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    step();
    req_valid = after;
    #1;
    chk({tag, "_issue_u_ready"}, 32'(u_ready), 32'd1);
    chk({tag, "_issue_u_en"}, 32'(u_en), 32'd1);
    chk({tag, "_issue_busy"}, 32'(busy), 32'd1);
    chk({tag, "_issue_u_in_x"}, 32'(u_in_x), 32'(exp_x));
    chk({tag, "_issue_req_ready"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_wait_u_ready"}, 32'(u_ready), 32'd0);
    n = 0;
    while (!resp_valid && n < 40) begin
      if (answer && n == lat) begin
        u_valid  = 1'b1;
        u_log2_x = ans;
      end else begin
        u_valid  = 1'b0;
      end
      step();
      n++;
    end
    u_valid = 1'b0;
    chk({tag, "_wait_cycles"}, 32'(n), answer ? 32'(lat + 1) : 32'(TO));
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'(exp_id));
    chk({tag, "_resp_data"}, 32'(resp_data), 32'(exp_data));
    chk({tag, "_resp_err"}, 32'(resp_err), 32'(!answer));
    chk({tag, "_resp_busy"}, 32'(busy), 32'd1);
    chk({tag, "_resp_u_en"}, 32'(u_en), 32'd0);
    chk({tag, "_resp_u_in_x"}, 32'(u_in_x), 32'(exp_x));
    step();
    chk({tag, "_post_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_resp_data"}, 32'(resp_data), 32'(exp_data));
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_x     = '0;
    u_valid   = 1'b0;
    u_log2_x  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_u_en", 32'(u_en), 32'd0);
    chk("rst_u_ready", 32'(u_ready), 32'd0);
    chk("rst_u_in_x", 32'(u_in_x), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    step();

    // Single requesters.
    req_x[0*W +: W] = 16'h1000;
    op("t1", 4'b0001, 4'b0000, 0, 16'h1000, 0, 1'b1, 16'h0000);
    req_x[1*W +: W] = 16'h0040;
    op("t2", 4'b0010, 4'b0000, 1, 16'h0040, 3, 1'b1, 16'hA000);

    // Restart the pointer at 0, then all four requesters contend.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 16'h2000;
    for (int k = 0; k < 8; k++)
      op($sformatf("t3_op%0d", k), 4'b1111, (k == 7) ? 4'b0000 : 4'b1111,
         k % 4, 16'h2000, k % 3, 1'b1, 16'h1000);

    // u_valid arriving on the last WAIT cycle beats the watchdog.
    req_x[0*W +: W] = 16'h3000;
    op("tie", 4'b0001, 4'b0000, 0, 16'h3000, TO - 1, 1'b1, 16'h0123);
    chk("tie_timeout_err", 32'(timeout_err), 32'd0);

    // Unit never answers.
    req_x[2*W +: W] = 16'h1800;
    op("t4", 4'b0100, 4'b0000, 2, 16'h1800, 0, 1'b0, 16'h0000);
    chk("t4_timeout_err", 32'(timeout_err), 32'd1);

    // Spurious unit pulse while idle, then a normal operation.
    u_valid  = 1'b1;
    u_log2_x = 16'h7777;
    step();
    u_valid = 1'b0;
    chk("t5_spur_resp_valid", 32'(resp_valid), 32'd0);
    chk("t5_spur_busy", 32'(busy), 32'd0);
    step();
    chk("t5_spur_resp_valid2", 32'(resp_valid), 32'd0);
    chk("t5_spur_resp_data", 32'(resp_data), 32'd0);
    req_x[3*W +: W] = 16'h4000;
    op("t5", 4'b1000, 4'b0000, 3, 16'h4000, 2, 1'b1, 16'h2000);
    chk("t5_timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT drops the op and returns the pointer to 0.
    req_x[1*W +: W] = 16'h1000;
    req_valid = 4'b0010;
    #1;
    chk("t6_req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    step();
    chk("t6_in_wait", 32'(u_en), 32'd1);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_u_en", 32'(u_en), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_u_in_x", 32'(u_in_x), 32'd0);
    chk("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_resp_data", 32'(resp_data), 32'd0);
    chk("t6_rst_resp_id", 32'(resp_id), 32'd0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 32'd0);
    step();
    chk("t6_held_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    req_x[0*W +: W] = 16'h0800;
    op("t6_after", 4'b1111, 4'b0000, 0, 16'h0800, 1, 1'b1, 16'hC000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
